// File: rtl/avmm_pkg.sv
// Shared widths, constants and the read-pipe slot type for the AVMM word memory.
package avmm_pkg;

    localparam int AVMM_DATA_W = 64;
    localparam int AVMM_BE_W   = 8;
    localparam int AVMM_ADDR_W = 32;

    // Returned for reads that fall outside the implemented words.
    localparam logic [AVMM_DATA_W-1:0] BAD_ADDR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct packed {
        logic                   valid;
        logic [AVMM_DATA_W-1:0] data;
    } rd_slot_t;

    // Merge new data into an old word, one byte lane per byteenable bit.
    function automatic logic [AVMM_DATA_W-1:0] be_merge(
        input logic [AVMM_DATA_W-1:0] old_w,
        input logic [AVMM_DATA_W-1:0] new_w,
        input logic [AVMM_BE_W-1:0]   be
    );
        logic [AVMM_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < AVMM_BE_W; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read return pipe: a slot enters per cycle, emerges LAT cycles later.
module avmm_rd_pipe
    import avmm_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rd_slot_t i_slot,
    output rd_slot_t o_slot
);

    rd_slot_t [LAT-1:0] r_pipe;

    // Shift slots toward the output; reset drops every read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_slot;
            for (int i = 1; i < LAT; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_slot = r_pipe[LAT-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave word memory with fixed read latency, bounded outstanding
// reads and a test hook that forces waitrequest.
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AVMM_ADDR_W-1:0] i_avs_address,
    input  logic                   i_avs_read,
    input  logic                   i_avs_write,
    input  logic [AVMM_DATA_W-1:0] i_avs_writedata,
    input  logic [AVMM_BE_W-1:0]   i_avs_byteenable,
    output logic [AVMM_DATA_W-1:0] o_avs_readdata,
    output logic                   o_avs_readdatavalid,
    output logic                   o_avs_waitrequest,
    input  logic                   i_stall_in,
    output logic [2:0]             o_pending_cnt,
    output logic                   o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AVMM_DATA_W-1:0] r_mem [DEPTH];
    logic                   r_rdy;
    logic [2:0]             r_pend;
    logic                   r_err;
    logic [AVMM_DATA_W-1:0] r_last;

    logic                   w_wait;
    logic                   w_in_range;
    logic [AW-1:0]          w_idx;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   w_coll;
    rd_slot_t               w_in;
    rd_slot_t               w_out;

    // Busy out of reset for one cycle, on test stall, or when the read window is full.
    assign w_wait     = !r_rdy | i_stall_in | (r_pend >= 3'(MAX_PENDING));
    assign w_in_range = i_avs_address < AVMM_ADDR_W'(DEPTH);
    assign w_idx      = i_avs_address[AW-1:0];

    // A read alongside a write loses: the write is performed, the read dropped.
    assign w_rd_acc = !w_wait & i_avs_read & !i_avs_write;
    assign w_wr_acc = !w_wait & i_avs_write;
    assign w_coll   = !w_wait & i_avs_read & i_avs_write;

    assign w_in.valid = w_rd_acc;
    assign w_in.data  = w_in_range ? r_mem[w_idx] : BAD_ADDR_DATA;

    avmm_rd_pipe #(.LAT(READ_LATENCY)) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_slot (w_in),
        .o_slot (w_out)
    );

    // Memory array: byte-lane writes, no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_acc && w_in_range)
            r_mem[w_idx] <= be_merge(r_mem[w_idx], i_avs_writedata, i_avs_byteenable);
    end

    // Control state: ready flag, pending reads, sticky error, held read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy  <= 1'b0;
            r_pend <= '0;
            r_err  <= 1'b0;
            r_last <= '0;
        end else begin
            r_rdy <= 1'b1;
            case ({w_rd_acc, w_out.valid})
                2'b10:   r_pend <= r_pend + 3'd1;
                2'b01:   r_pend <= r_pend - 3'd1;
                default: r_pend <= r_pend;
            endcase
            if (((w_rd_acc | w_wr_acc) & !w_in_range) | w_coll)
                r_err <= 1'b1;
            if (w_out.valid)
                r_last <= w_out.data;
        end
    end

    assign o_avs_waitrequest   = w_wait;
    assign o_avs_readdatavalid = w_out.valid;
    assign o_avs_readdata      = w_out.valid ? w_out.data : r_last;
    assign o_pending_cnt       = r_pend;
    assign o_err               = r_err;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_avmm_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;
    logic        stall = 1'b0;
    logic [63:0] o_rdata;
    logic        o_valid;
    logic        o_wait;
    logic [2:0]  o_pend;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avmm_mem_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_avs_address       (addr),
        .i_avs_read          (rd),
        .i_avs_write         (wr),
        .i_avs_writedata     (wdata),
        .i_avs_byteenable    (be),
        .o_avs_readdata      (o_rdata),
        .o_avs_readdatavalid (o_valid),
        .o_avs_waitrequest   (o_wait),
        .i_stall_in          (stall),
        .o_pending_cnt       (o_pend),
        .o_err               (o_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_mem [16];
    logic        m_err;
    logic        m_rdy;
    logic [63:0] m_last;
    int          cyc = 0;
    bit          m_acc;

    function automatic bit m_wait();
        return !m_rdy || stall || (q.size() >= 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_err  = 1'b0;
            m_rdy  = 1'b0;
            m_last = '0;
        end else begin
            m_acc = !m_wait() && (rd || wr);
            if (m_acc && wr) begin
                if (addr < 16) begin
                    for (int b = 0; b < 8; b++)
                        if (be[b]) m_mem[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    m_err = 1'b1;
                end
                if (rd) m_err = 1'b1;
            end else if (m_acc && rd) begin
                q.push_back('{cyc + 3, (addr < 16) ? m_mem[addr[3:0]] : 64'hDEAD_BEEF_DEAD_BEEF});
                if (addr >= 16) m_err = 1'b1;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                m_last = q[0].data;
                void'(q.pop_front());
            end
            m_rdy = 1'b1;
        end
        cyc++;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        ev;
        logic [63:0] ed;
        ev = 1'b0;
        ed = m_last;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1'b1;
            ed = q[0].data;
        end
        chk("waitrequest", 64'(o_wait), 64'(m_wait()));
        chk("readdatavalid", 64'(o_valid), 64'(ev));
        chk("readdata", o_rdata, ed);
        chk("pending_cnt", 64'(o_pend), 64'(q.size()));
        chk("err", 64'(o_err), 64'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit r, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] b);
        bit done;
        done = 1'b0;
        rd = r; wr = w; addr = a; wdata = d; be = b;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = !o_wait;
            tick();
        end
        chk("req_accepted", 64'(done), 64'd1);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_lat(input logic [31:0] a, output int lat, output logic [63:0] d);
        req(1'b1, 1'b0, a, '0, '0);
        lat = 0;
        d   = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (o_valid) begin
                d = o_rdata;
                break;
            end
        end
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int          lat;
        logic [63:0] d;
        int          nw;
        int          nv;
        bit          ok;

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait", 64'(o_wait), 64'd1);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wait_c1", 64'(o_wait), 64'd1);
        chk("post_rst_pend", 64'(o_pend), 64'd0);
        tick();
        @(negedge clk);
        chk("post_rst_wait_c2", 64'(o_wait), 64'd0);
        tick();

        // Fill all words with known data, word 0 last.
        for (int i = 1; i < 16; i++)
            req(1'b0, 1'b1, i, {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)}, 8'hFF);
        req(1'b0, 1'b1, 0, 64'h0102_0304_0506_0708, 8'hFF);

        rd_lat(0, lat, d);
        chk("rd0_latency", 64'(lat), 64'd3);
        chk("rd0_data", d, 64'h0102_0304_0506_0708);

        req(1'b0, 1'b1, 0, '1, 8'h0F);
        rd_lat(0, lat, d);
        chk("partial_be_data", d, 64'h0102_0304_FFFF_FFFF);

        // Read held across addresses 0,1,2: window of two outstanding reads.
        rd = 1'b1; addr = 0;
        @(negedge clk);
        chk("pipe_c0_wait", 64'(o_wait), 64'd0);
        tick();
        addr = 1;
        @(negedge clk);
        chk("pipe_c1_wait", 64'(o_wait), 64'd0);
        tick();
        addr = 2;
        @(negedge clk);
        chk("pipe_c2_wait", 64'(o_wait), 64'd1);
        chk("pipe_c2_pend", 64'(o_pend), 64'd2);
        nw = 1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (!o_wait) begin
                ok = 1'b1;
                break;
            end
            nw++;
        end
        chk("third_accept", 64'(ok), 64'd1);
        chk("third_wait_cycles", 64'(nw), 64'd2);
        tick();
        rd = 1'b0;
        repeat (6) tick();

        // Forced backpressure with a read held.
        stall = 1'b1; rd = 1'b1; addr = 3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_wait", 64'(o_wait), 64'd1);
            chk("stall_no_valid", 64'(o_valid), 64'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_wait", 64'(o_wait), 64'd0);
        tick();
        rd = 1'b0;
        repeat (6) tick();

        // Out-of-range read.
        rd_lat(20, lat, d);
        chk("oob_latency", 64'(lat), 64'd3);
        chk("oob_data", d, 64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        chk("oob_err", 64'(o_err), 64'd1);
        tick();

        // Read+write collision: write lands, read is dropped.
        req(1'b1, 1'b1, 5, 64'h1111_2222_3333_4444, 8'hFF);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_valid) nv++;
            tick();
        end
        chk("coll_no_valid", 64'(nv), 64'd0);
        rd_lat(5, lat, d);
        chk("coll_write_landed", d, 64'h1111_2222_3333_4444);

        // Reset with two reads in flight.
        rd = 1'b1; addr = 0;
        tick();
        addr = 1;
        tick();
        rd = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_valid) nv++;
            tick();
        end
        chk("rst_flush_no_valid", 64'(nv), 64'd0);
        @(negedge clk);
        chk("rst_err_clear", 64'(o_err), 64'd0);
        tick();
        rd_lat(0, lat, d);
        chk("mem_retained", d, 64'h0102_0304_FFFF_FFFF);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
